refresh_scheduler: RTL

Consumes the single-cycle `refresh_flag` tick from the refresh interval counter and turns it into correctly sequenced refresh traffic for the DRAM command path. It keeps a count of owed refreshes, postponing them while the controller is busy, up to a limit. It holds off normal traffic, precharges open banks, issues REF, and enforces tRP/tRFC. It sits between the refresh counter and the command arbiter.

---
 rtl/refresh_scheduler.sv | 86 ++++++++
 1 files changed

// File: rtl/refresh_scheduler.sv
// refresh_scheduler: postpones, sequences (PREA/REF) and times DRAM refreshes; define REFRESH_BURST_EN for back-to-back REF bursts
module refresh_scheduler #(
   parameter int MAX_PENDING   = 8,
   parameter int URGENT_THRESH = 4,
   parameter int T_RP          = 3,
   parameter int T_RFC         = 30
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               refresh_flag,
   input  logic                               ctrl_idle,
   input  logic                               bank_open,
   input  logic                               cmd_ready,
   output logic                               cmd_valid,
   output logic [1:0]                         cmd_op,
   output logic                               ref_hold,
   output logic                               ref_urgent,
   output logic                               ref_done,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
   output logic                               ref_overflow
);
   localparam int PW = $clog2(MAX_PENDING + 1);
   localparam int CW = $clog2((T_RFC > T_RP ? T_RFC : T_RP) + 1);
   typedef enum logic [2:0] {IDLE, DRAIN, PREA, WAIT_RP, REF, WAIT_RFC} state_t;
   state_t state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic accept, ref_accept, burst, ref_done_d;
   assign accept = cmd_valid & cmd_ready;
   assign ref_accept = accept & (state == REF);
`ifdef REFRESH_BURST_EN
   assign burst = 1'b1;
`else
   assign burst = 1'b0;
`endif
   assign ref_urgent = pending >= PW'(URGENT_THRESH);
   assign cmd_op = !cmd_valid ? 2'b00 : (state == REF) ? 2'b10 : 2'b01;
   assign ref_done_d = (ref_accept && T_RFC == 1) || (state == WAIT_RFC && cnt == CW'(1));
   always_comb begin
      state_d = state;
      cnt_d = cnt;
      case (state)
         IDLE: if (pending != '0 && (ctrl_idle || ref_urgent)) state_d = DRAIN;
         DRAIN: if (ctrl_idle) state_d = bank_open ? PREA : REF;
         PREA: if (accept) begin
            state_d = (T_RP == 1) ? REF : WAIT_RP;
            cnt_d = CW'(T_RP - 1);
         end
         WAIT_RP: begin
            state_d = (cnt == CW'(1)) ? REF : WAIT_RP;
            cnt_d = cnt - CW'(1);
         end
         REF: if (accept) begin
            state_d = WAIT_RFC;
            cnt_d = CW'(T_RFC - 1);
         end
         WAIT_RFC: begin
            state_d = (cnt != '0) ? WAIT_RFC : (burst && pending != '0) ? REF : IDLE;
            cnt_d = cnt - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         cmd_valid <= 1'b0;
         ref_hold <= 1'b0;
         ref_done <= 1'b0;
         pending <= '0;
         ref_overflow <= 1'b0;
      end else begin
         state <= state_d;
         cnt <= cnt_d;
         cmd_valid <= state_d == PREA || state_d == REF;
         ref_hold <= state_d != IDLE;
         ref_done <= ref_done_d;
         if (refresh_flag && !ref_accept) begin
            if (pending == PW'(MAX_PENDING)) ref_overflow <= 1'b1;
            else pending <= pending + PW'(1);
         end else if (ref_accept && !refresh_flag) begin
            pending <= pending - PW'(1);
         end
      end
   end
endmodule
